// File: rtl/operand_collector.sv
// operand_collector: single-entry operand collector between warp issue and the ALU.
// Accepts one instruction, reads its pending sources (rs1, rs2, rs3 in that order)
// through one synchronous register-file read port, then holds a registered bundle.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   issue_*                instruction offer (valid/ready), fields latched on accept
//   rf_rd_en/warp/addr     read request; rf_rd_data returns the cycle after
//   disp_*                 registered operand bundle (valid/ready)
module operand_collector #(
    parameter int WARP_SIZE = 32,
    parameter int REG_AW    = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      issue_valid,
    output logic                      issue_ready,
    input  logic [7:0]                issue_op,
    input  logic [4:0]                issue_warp,
    input  logic [31:0]               issue_imm,
    input  logic [REG_AW-1:0]         issue_rs1,
    input  logic [REG_AW-1:0]         issue_rs2,
    input  logic [REG_AW-1:0]         issue_rs3,
    input  logic [2:0]                issue_use,
    input  logic [REG_AW-1:0]         issue_rd,
    input  logic [WARP_SIZE-1:0]      issue_mask,
    input  logic [WARP_SIZE-1:0]      issue_src_pred,
    output logic                      rf_rd_en,
    output logic [4:0]                rf_rd_warp,
    output logic [REG_AW-1:0]         rf_rd_addr,
    input  logic [WARP_SIZE-1:0][31:0] rf_rd_data,
    output logic                      disp_valid,
    input  logic                      disp_ready,
    output logic [7:0]                disp_op,
    output logic [4:0]                disp_warp,
    output logic [31:0]               disp_imm,
    output logic [REG_AW-1:0]         disp_rd,
    output logic [WARP_SIZE-1:0]      disp_mask,
    output logic [WARP_SIZE-1:0]      disp_src_pred,
    output logic [WARP_SIZE-1:0][31:0] disp_rs1,
    output logic [WARP_SIZE-1:0][31:0] disp_rs2,
    output logic [WARP_SIZE-1:0][31:0] disp_rs3
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DISP
    } state_e;

    state_e                     state_q;
    logic [2:0]                 pend_q, pend_d;
    logic [1:0]                 tag_q;
    logic                       tagv_q;
    logic [REG_AW-1:0]          rs1_q, rs2_q, rs3_q;
    logic [7:0]                 op_q;
    logic [4:0]                 warp_q;
    logic [31:0]                imm_q;
    logic [REG_AW-1:0]          rd_q;
    logic [WARP_SIZE-1:0]       mask_q, pred_q;
    logic [WARP_SIZE-1:0][31:0] opnd1_q, opnd2_q, opnd3_q;

    logic                       accept;
    logic [2:0]                 use_pend;
    logic [1:0]                 cur_idx;
    logic [REG_AW-1:0]          cur_addr;

    always_comb begin
        issue_ready = (state_q == S_IDLE) | ((state_q == S_DISP) & disp_ready);
        accept      = issue_valid & issue_ready;
        // Register 0 is hardwired zero, so it never needs a read.
        use_pend    = {issue_use[2] & (issue_rs3 != '0),
                       issue_use[1] & (issue_rs2 != '0),
                       issue_use[0] & (issue_rs1 != '0)};
        // Lowest pending source is read first.
        cur_idx  = 2'd2;
        cur_addr = rs3_q;
        pend_d   = pend_q & 3'b011;
        if (pend_q[0]) begin
            cur_idx  = 2'd0;
            cur_addr = rs1_q;
            pend_d   = pend_q & 3'b110;
        end else if (pend_q[1]) begin
            cur_idx  = 2'd1;
            cur_addr = rs2_q;
            pend_d   = pend_q & 3'b101;
        end
        rf_rd_en   = (state_q == S_READ);
        rf_rd_warp = rf_rd_en ? warp_q : '0;
        rf_rd_addr = rf_rd_en ? cur_addr : '0;
        disp_valid = (state_q == S_DISP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pend_q  <= '0;
            tag_q   <= '0;
            tagv_q  <= 1'b0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rs3_q   <= '0;
            op_q    <= '0;
            warp_q  <= '0;
            imm_q   <= '0;
            rd_q    <= '0;
            mask_q  <= '0;
            pred_q  <= '0;
            opnd1_q <= '0;
            opnd2_q <= '0;
            opnd3_q <= '0;
        end else begin
            // Data for the read issued last cycle lands in the tagged slot.
            if (tagv_q) begin
                unique case (tag_q)
                    2'd0:    opnd1_q <= rf_rd_data;
                    2'd1:    opnd2_q <= rf_rd_data;
                    default: opnd3_q <= rf_rd_data;
                endcase
            end
            unique case (state_q)
                S_IDLE, S_DISP: begin
                    if (accept) begin
                        op_q    <= issue_op;
                        warp_q  <= issue_warp;
                        imm_q   <= issue_imm;
                        rd_q    <= issue_rd;
                        mask_q  <= issue_mask;
                        pred_q  <= issue_src_pred;
                        rs1_q   <= issue_rs1;
                        rs2_q   <= issue_rs2;
                        rs3_q   <= issue_rs3;
                        opnd1_q <= '0;
                        opnd2_q <= '0;
                        opnd3_q <= '0;
                        pend_q  <= use_pend;
                        state_q <= (use_pend != '0) ? S_READ : S_DISP;
                    end else if (state_q == S_DISP && disp_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                S_READ: begin
                    pend_q <= pend_d;
                    tag_q  <= cur_idx;
                    tagv_q <= 1'b1;
                    if (pend_d == '0) state_q <= S_DRAIN;
                end
                S_DRAIN: begin
                    tagv_q  <= 1'b0;
                    state_q <= S_DISP;
                end
            endcase
        end
    end

    assign disp_op       = op_q;
    assign disp_warp     = warp_q;
    assign disp_imm      = imm_q;
    assign disp_rd       = rd_q;
    assign disp_mask     = mask_q;
    assign disp_src_pred = pred_q;
    assign disp_rs1      = opnd1_q;
    assign disp_rs2      = opnd2_q;
    assign disp_rs3      = opnd3_q;

endmodule

// File: doc/operand_collector.md
# operand_collector

Single-entry operand collector between the warp issue stage and the combinational integer ALU. It accepts one issued instruction, fetches the needed source registers (rs1, rs2, rs3) through one synchronous register-file read port, and presents a fully populated, registered operand bundle to the ALU inputs (op, warp, imm, rs1/rs2/rs3, src_pred) with a valid/ready handshake. Register 0 reads as zero and costs no read cycle.

## Interface
- WARP_SIZE, 32, lanes per warp; width of per-lane vectors.
- REG_AW, 6, register index width (64 architectural registers per warp).
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous and active-high.
- issue_valid  in  1  instruction offered.
- issue_ready  out  1  collector can accept.
- issue_op  in  8  opcode (opcode_e encoding).
- issue_warp  in  5  warp id.
- issue_imm  in  32  immediate.
- issue_rs1 / issue_rs2 / issue_rs3  in  REG_AW each  source indices.
- issue_use  in  3  bit0/1/2: rs1/rs2/rs3 needed.
- issue_rd  in  REG_AW  destination, passed through.
- issue_mask  in  WARP_SIZE  active-lane mask, passed through.
- issue_src_pred  in  WARP_SIZE  per-lane predicate, passed through.
- rf_rd_en  out  1  read request this cycle.
- rf_rd_warp  out  5  read warp.
- rf_rd_addr  out  REG_AW  read register.
- rf_rd_data  in  WARP_SIZE×32  read data, valid the cycle after rf_rd_en.
- disp_valid  out  1  operand bundle valid.
- disp_ready  in  1  ALU/downstream consumes.
- disp_op, disp_warp, disp_imm, disp_rd, disp_mask, disp_src_pred  out  widths as issue_*  latched fields.
- disp_rs1 / disp_rs2 / disp_rs3  out  WARP_SIZE×32 each  collected operands.

## Operation
- States: IDLE, READ, DRAIN, DISP.
- issue_ready = (state==IDLE) | (state==DISP & disp_ready). Accept = issue_valid & issue_ready; latches all issue fields and clears disp_rs1/2/3 to zero.
- Pending set at accept: source k pending iff issue_use[k] & (index != 0). Unused or zero-index sources stay zero.
- n = number of pending sources (0..3). n==0: next state DISP. n>=1: next state READ.
- READ: one read per cycle in fixed order rs1, rs2, rs3 (skipping non-pending); rf_rd_en=1, rf_rd_warp=latched warp, rf_rd_addr=current source. After issuing the last read -> DRAIN.
- Data capture: rf_rd_data in cycle after each read is written into the slot of the source read in the previous cycle (one-entry tag register); captures overlap following reads.
- DRAIN: capture final data; -> DISP.
- DISP: disp_valid=1, all disp_* stable. disp_ready=1 -> IDLE, or directly to new accept if issue_valid (zero-bubble back-to-back).
- rf_rd_en=0 in IDLE, DRAIN, DISP. rf_rd_warp/addr drive zero when rf_rd_en=0.
- No hazard checking: upstream scoreboard guarantees sources are not in flight.
- Reset (any state): state=IDLE, all latched fields and operands zero, pending read data discarded.

## Timing
- Reset values: issue_ready=1 (after rst deasserts), rf_rd_en=0, rf_rd_warp=0, rf_rd_addr=0, disp_valid=0, all disp_* =0.
- Accept edge ends cycle T. Reads in cycles T+1..T+n. Last data arrives T+n+1. disp_valid from T+n+2 (n>=1); from T+1 (n==0).
- disp_* registered, change only on an accept edge or reset; stable while disp_valid & !disp_ready.
- Throughput: one instruction per n+2 cycles (n>=1), one per cycle for n==0 with disp_ready held high.
- issue_ready is low throughout READ and DRAIN; issue_* ignored then.
- rst asserted mid-READ: rf_rd_en drops asynchronously; data returning next cycle ignored.

## Test plan
- ADD warp 3, rs1=R5 (lane l = l), rs2=R7 (lane l = 100), use=3'b011, imm=2: reads R5 at T+1, R7 at T+2, disp_valid at T+4, disp_rs1[l]=l, disp_rs2[l]=100, disp_rs3=0, disp_imm=2.
- IMAD use=3'b111, rs2=R0: only two reads (rs1, rs3) at T+1, T+2; disp_rs2 all zero; disp_valid at T+4.
- OP_TID use=3'b000: no rf_rd_en ever; disp_valid at T+1, operands zero.
- Backpressure: disp_ready low 5 cycles in DISP -> disp_* constant, issue_ready=0, rf_rd_en=0; raise disp_ready with issue_valid -> new instruction accepted same edge, disp_valid low next cycle if n>=1.
- Back-to-back n==0 instructions, disp_ready=1: disp_valid high every cycle, disp_op tracks each issue one cycle later.
- rst pulse during READ of a 3-source op: all outputs zero immediately, issue_ready=1 after release, no disp_valid for the aborted instruction.
